sample_packer: RTL and testbench



---
 rtl/sample_packer.sv | 135 +++++++++++++
 tb/tb_sample_packer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sample_packer.sv
// Buffers timetag records in a small FIFO and streams each one LSB-byte-first over the FX2 byte handshake.
// Optional dropped-record counter enabled by defining SAMPLE_PACKER_LOST_COUNT_EN.
module sample_packer #(
  parameter int REC_BYTES = 6,
  parameter int DEPTH     = 4
) (
  input  logic                   fx2_clk,
  input  logic                   reset,
  input  logic [8*REC_BYTES-1:0] rec_in,
  input  logic                   rec_wr,
  output logic                   rec_full,
  output logic [7:0]             sample,
  output logic                   sample_rdy,
  input  logic                   sample_ack,
  output logic [15:0]            lost_count
);

  localparam int W    = 8 * REC_BYTES;
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = PTRW + 1;
  localparam int IDXW = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(REC_BYTES - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [W-1:0]    r_mem [DEPTH];
  logic [PTRW-1:0] r_wrPtr;
  logic [PTRW-1:0] r_rdPtr;
  logic [CNTW-1:0] r_count;
  logic            r_full;
  logic [W-1:0]    r_shift;
  logic [IDXW-1:0] r_byteIdx;

  logic            w_empty;
  logic            w_wrAccept;
  logic            w_fire;
  logic            w_lastByte;
  logic            w_pop;
  logic [CNTW-1:0] w_countNext;

  assign w_empty    = (r_count == '0);
  assign w_wrAccept = rec_wr && !r_full;
  assign sample_rdy = (r_state == S_SEND);
  assign w_fire     = sample_rdy && sample_ack;
  assign w_lastByte = (r_byteIdx == LAST_IDX);
  assign sample     = r_shift[7:0];
  assign rec_full   = r_full;

  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nextState = S_SEND;
        end
      end
      S_SEND: begin
        // Refill straight from the FIFO on the final byte so records stream without a gap
        if (w_fire && w_lastByte) begin
          if (!w_empty) w_pop = 1'b1;
          else          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge fx2_clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_ff @(posedge fx2_clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_byteIdx <= '0;
    end else if (w_pop) begin
      r_shift   <= r_mem[r_rdPtr];
      r_byteIdx <= '0;
    end else if (w_fire && !w_lastByte) begin
      r_shift   <= r_shift >> 8;
      r_byteIdx <= r_byteIdx + 1'b1;
    end
  end

  always_comb begin
    w_countNext = r_count;
    if (w_wrAccept && !w_pop)      w_countNext = r_count + 1'b1;
    else if (!w_wrAccept && w_pop) w_countNext = r_count - 1'b1;
  end

  always_ff @(posedge fx2_clk) begin
    if (w_wrAccept) r_mem[r_wrPtr] <= rec_in;
  end

  always_ff @(posedge fx2_clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_wrAccept) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)      r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= w_countNext;
      r_full  <= (w_countNext == FULL_CNT);
    end
  end

`ifdef SAMPLE_PACKER_LOST_COUNT_EN
  logic [15:0] r_lostCount;

  // Drops are judged against the registered full flag, so a same-cycle pop does not rescue the write
  always_ff @(posedge fx2_clk) begin
    if (reset)
      r_lostCount <= '0;
    else if (rec_wr && r_full && (r_lostCount != 16'hFFFF))
      r_lostCount <= r_lostCount + 1'b1;
  end

  assign lost_count = r_lostCount;
`else
  assign lost_count = 16'h0000;
`endif

endmodule

// File: tb/tb_sample_packer.sv
// Self-checking bench for sample_packer: directed scenarios plus a random phase against a queue-based model.
module tb_sample_packer;

  localparam int REC_BYTES = 6;
  localparam int DEPTH     = 4;
  localparam int W         = 8 * REC_BYTES;
`ifdef SAMPLE_PACKER_LOST_COUNT_EN
  localparam int EXP_FILL_LOST = 2;
`else
  localparam int EXP_FILL_LOST = 0;
`endif

  logic          fx2_clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  rec_in = '0;
  logic          rec_wr = 1'b0;
  logic          rec_full;
  logic [7:0]    sample;
  logic          sample_rdy;
  logic          sample_ack = 1'b0;
  logic [15:0]   lost_count;

  sample_packer #(.REC_BYTES(REC_BYTES), .DEPTH(DEPTH)) dut (
    .fx2_clk    (fx2_clk),
    .reset      (reset),
    .rec_in     (rec_in),
    .rec_wr     (rec_wr),
    .rec_full   (rec_full),
    .sample     (sample),
    .sample_rdy (sample_rdy),
    .sample_ack (sample_ack),
    .lost_count (lost_count)
  );

  always #5 fx2_clk = ~fx2_clk;

  // Reference model: whole records waiting, plus bytes still owed from the record in flight
  logic [W-1:0] mFifo[$];
  logic [7:0]   mCur[$];
  bit           mFull;
  int           mLost;

  int checks = 0;
  int errors = 0;
  int fires;
  int curRun;
  int maxRun;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge();
    bit rdy;
    bit fire;
    bit needPop;
    logic [W-1:0] rec;
    if (reset) begin
      mFifo.delete();
      mCur.delete();
      mFull = 1'b0;
      mLost = 0;
      return;
    end
    rdy  = (mCur.size() > 0);
    fire = rdy && sample_ack;
    if (fire) void'(mCur.pop_front());
    needPop = !rdy || (fire && mCur.size() == 0);
    if (needPop && mFifo.size() > 0) begin
      rec = mFifo.pop_front();
      for (int b = 0; b < REC_BYTES; b++) mCur.push_back(rec[8*b +: 8]);
    end
    if (rec_wr) begin
      if (mFull) begin
`ifdef SAMPLE_PACKER_LOST_COUNT_EN
        if (mLost < 65535) mLost++;
`endif
      end else begin
        mFifo.push_back(rec_in);
      end
    end
    mFull = (mFifo.size() == DEPTH);
  endtask

  task automatic checkOutput();
    check("rdy", W'(sample_rdy), W'(mCur.size() > 0));
    if (mCur.size() > 0) check("sample", W'(sample), W'(mCur[0]));
    check("full", W'(rec_full), W'(mFull));
    check("lost", W'(lost_count), W'(mLost));
    if (sample_rdy) begin
      curRun++;
      if (curRun > maxRun) maxRun = curRun;
    end else begin
      curRun = 0;
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [W-1:0] rec, input logic ack);
    rec_wr     = wr;
    rec_in     = rec;
    sample_ack = ack;
    if (sample_rdy && ack) fires++;
    @(posedge fx2_clk);
    modelEdge();
    @(negedge fx2_clk);
    checkOutput();
  endtask

  task automatic doReset(input int cycles);
    reset      = 1'b1;
    rec_wr     = 1'b0;
    sample_ack = 1'b0;
    repeat (cycles) begin
      @(posedge fx2_clk);
      modelEdge();
    end
    @(negedge fx2_clk);
    reset = 1'b0;
    check("rst_rdy", W'(sample_rdy), W'(0));
    check("rst_sample", W'(sample), W'(0));
    check("rst_full", W'(rec_full), W'(0));
    check("rst_lost", W'(lost_count), W'(0));
  endtask

  function automatic logic [W-1:0] randRec();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  initial begin
    curRun = 0;
    maxRun = 0;
    doReset(2);

    // Single record with ack held high
    applyStimulus(1'b1, 48'h0605_0403_0201, 1'b1);
    repeat (9) applyStimulus(1'b0, '0, 1'b1);

    // Backpressure: ack pattern 1,0,0,1 repeating
    fires = 0;
    applyStimulus(1'b1, randRec(), 1'b1);
    for (int i = 0; i < 24; i++) applyStimulus(1'b0, '0, (i % 4 == 0) || (i % 4 == 3));
    check("bp_fires", W'(fires), W'(6));

    // Fill: park one record in the serializer, then overfill the FIFO
    applyStimulus(1'b1, randRec(), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, randRec(), 1'b0);
      if (i == 3) check("fill_full", W'(rec_full), W'(1));
    end
    check("fill_lost", W'(lost_count), W'(EXP_FILL_LOST));
    repeat (36) applyStimulus(1'b0, '0, 1'b1);
    check("fill_drained", W'(sample_rdy), W'(0));

    // Back-to-back records with no boundary gap
    maxRun = 0;
    repeat (3) applyStimulus(1'b1, randRec(), 1'b1);
    repeat (20) applyStimulus(1'b0, '0, 1'b1);
    check("b2b_run", W'(maxRun), W'(18));

    // Wrap-around: 10 records in bursts of 3
    for (int n = 0; n < 10; n += 3) begin
      for (int k = 0; k < 3 && n + k < 10; k++) applyStimulus(1'b1, randRec(), 1'b1);
      repeat (20) applyStimulus(1'b0, '0, 1'b1);
    end

    // Random traffic with drops and backpressure
    repeat (400) applyStimulus(($urandom_range(0, 2) != 0), randRec(), ($urandom_range(0, 2) == 0));

    // Reset mid-stream: byte 3 showing, two records buffered
    repeat (40) applyStimulus(1'b0, '0, 1'b1);
    repeat (3) applyStimulus(1'b1, randRec(), 1'b1);
    repeat (2) applyStimulus(1'b0, '0, 1'b1);
    check("mid_buffered", W'(mFifo.size()), W'(2));
    doReset(1);
    applyStimulus(1'b1, 48'hAABB_CCDD_EEFF, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    check("post_rst_byte0", W'(sample), W'(8'hFF));
    repeat (8) applyStimulus(1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
